// File: rtl/grid_scan_driver.sv
// Row-scanned 8x8 LED matrix driver with frame-synchronous double buffering of the life grid.
// Optional population counter enabled by defining GRID_SCAN_POP_EN.
module grid_scan_driver #(
    parameter int CLK_DIV      = 1000,
    parameter int BLANK_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] grid,
    input  logic        grid_valid,
    output logic [7:0]  row,
    output logic [7:0]  col,
    output logic        frame_done,
    output logic [6:0]  alive_count
);

    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] TICK_AT = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] BLANK_P = PW'(BLANK_CYCLES);

    logic [PW-1:0] prescaler;
    logic [2:0]    row_idx;
    logic [63:0]   shadow;
    logic [63:0]   disp;
    logic          pending;
    logic          tick;
    logic          boundary;
    logic [7:0]    disp_row;

    assign tick     = (prescaler == TICK_AT);
    assign boundary = tick && (row_idx == 3'd7);
    assign disp_row = disp[{row_idx, 3'b000} +: 8];

    // NOTE: all state below is updated with <= so every register sees the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler  <= '0;
            row_idx    <= '0;
            shadow     <= '0;
            disp       <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= boundary;
            if (tick) begin
                prescaler <= '0;
                row_idx   <= row_idx + 3'd1;
            end else begin
                prescaler <= prescaler + 1'b1;
            end

            if (grid_valid)
                shadow <= grid;

            // A strobe on the boundary cycle bypasses the shadow so it is shown in the very next frame.
            if (boundary) begin
                if (grid_valid)
                    disp <= grid;
                else if (pending)
                    disp <= shadow;
                pending <= 1'b0;
            end else if (grid_valid) begin
                pending <= 1'b1;
            end
        end
    end

    // NOTE: defaults first so no path through this block leaves row/col unassigned (no latch).
    always_comb begin
        row = '0;
        col = '0;
        if (prescaler >= BLANK_P) begin
            row = 8'b1 << row_idx;
            col = disp_row;
        end
    end

`ifdef GRID_SCAN_POP_EN
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++)
            n = n + {3'b000, v[i]};
        return n;
    endfunction

    logic [6:0] acc;
    logic [6:0] row_pop;

    assign row_pop = {3'b000, popcount8(disp_row)};

    // Row 7 is folded in at the boundary, before the swap, so the count matches what was displayed.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc         <= '0;
            alive_count <= '0;
        end else if (boundary) begin
            alive_count <= acc + row_pop;
            acc         <= '0;
        end else if (tick) begin
            acc <= acc + row_pop;
        end
    end
`else
    assign alive_count = '0;
`endif

endmodule

// File: doc/grid_scan_driver.md
Name: grid_scan_driver

Overview:
- Downstream consumer of the 64-bit life grid from the top-level game block.
- Drives an 8x8 LED matrix by time-multiplexed row scanning.
- Double-buffers the grid so a new generation is only shown at a frame boundary, which prevents tearing.
- Reports a per-frame pulse and the live-cell population of the frame just displayed.

Parameters:
- CLK_DIV, 1000: clk cycles per row slot (>= 2).
- BLANK_CYCLES, 8: cycles at the start of each row slot with all outputs blanked, for anti-ghosting. Must be < CLK_DIV.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- grid  in  64  current generation; bit index = r*8 + c (row r, column c).
- grid_valid  in  1  one-cycle strobe; grid is valid this cycle.
- row  out  8  one-hot row select, active-high; bit r drives row r.
- col  out  8  column data for the active row, active-high; col[c] = cell (r,c).
- frame_done  out  1  one-cycle pulse at each frame boundary.
- alive_count  out  7  population of the last completed frame (0..64).

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: all registers and outputs are 0 (prescaler, row_idx, shadow, disp, pending, accumulator, row, col, frame_done, alive_count).
- Reset mid-operation: the scan restarts at row 0, prescaler 0, and the display goes blank. Any pending grid is discarded.
- Prescaler: counts 0..CLK_DIV-1. tick = (prescaler == CLK_DIV-1), after which it wraps to 0.
- Row index: row_idx (3 bits) increments on tick and wraps 7->0.
- Frame boundary: boundary = tick && row_idx == 7. Frame length = 8*CLK_DIV cycles.
- Outputs are a combinational decode of registered state:
  - Blank window, prescaler < BLANK_CYCLES: row = 0, col = 0.
  - Otherwise: row = 1 << row_idx, col = disp[row_idx*8 +: 8].
- Shadow capture: grid_valid loads shadow <= grid and sets pending <= 1. The latest strobe within a frame wins.
- Buffer swap on boundary:
  - If grid_valid is asserted in the same cycle: disp <= grid (bypass) and pending <= 0.
  - Else if pending: disp <= shadow and pending <= 0.
  - Else: disp holds.
- No mid-frame update: disp never changes except on boundary or reset.
- frame_done: 1 for exactly the cycle after boundary (registered pulse).
- Population counting:
  - On each tick with row_idx != 7: acc <= acc + popcount(disp[row_idx*8 +: 8]).
  - On boundary: alive_count <= acc + popcount(row 7 of current disp, pre-swap) and acc <= 0.
  - alive_count therefore describes the frame just displayed. It updates in the same cycle frame_done asserts, and holds between boundaries.
- Arithmetic widths: acc is 7 bits. The maximum of 64 fits, so overflow is impossible.

Optional Feature:
- Macro: GRID_SCAN_POP_EN.
- Defined: acc and popcount logic are present and alive_count behaves as specified.
- Undefined: no popcount logic or accumulator is built. alive_count is tied to 0. All other behaviour is identical.

Test Plan:
(All scenarios use CLK_DIV=4, BLANK_CYCLES=1, so frame = 32 cycles.)
1. Reset held for 5 cycles, then released -> row=0, col=0 and frame_done=0 during reset. First cycle after release is blank. Next cycle row=8'h01, col=8'h00. row sequences 01,02,...,80 every 4 cycles, and frame_done pulses every 32 cycles.
2. grid=64'h0000_0000_E000_0000 with grid_valid in cycle 10 of a frame -> col stays 0 until the boundary. The following frame shows row=8'h08 with col=8'hE0 and all other rows col=0. alive_count=3 at the end of that frame (with GRID_SCAN_POP_EN).
3. Two grid_valid strobes in one frame (64'hFF, then 64'hFF00) -> the next frame shows only row 1 col=8'hFF and row 0 col=0. alive_count=8 one frame later.
4. grid_valid with grid=64'hFFFF_FFFF_FFFF_FFFF exactly on the boundary cycle -> displayed in the very next frame: every row col=8'hFF. The following frame_done reports alive_count=64.
5. Pending grid loaded, then reset asserted for 1 cycle mid-frame before the boundary -> outputs go to 0. After release the display stays blank (pending discarded) and alive_count=0 on the next frame_done.
6. Build without GRID_SCAN_POP_EN, rerun scenario 4 -> identical row/col/frame_done; alive_count constantly 0.
